// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sequencer for the 8-function NAND-based gate unit.
// Latency: each enabled vector is held SETTLE cycles; done pulses one cycle after the last sample.
// Backpressure: none; start is ignored unless IDLE, abort cancels a run. Optional: GATE_BIST_STOP_ON_FAIL_EN.
module gate_bist_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter logic [31:0] GOLDEN = 32'h3396_1E87
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  sel_mask,
  output logic        dut_a,
  output logic        dut_b,
  output logic [2:0]  dut_sel,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  fail_count,
  output logic [4:0]  first_fail_idx,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t      r_state;
  logic [7:0]  r_mask;
  logic [4:0]  r_idx;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [5:0]  r_fc;
  logic [4:0]  r_ffi;
  logic [31:0] r_result;

  logic [3:0]  w_first;
  logic [3:0]  w_next;
  logic        w_last_in_grp;
  logic        w_nxt_vld;
  logic [4:0]  w_nxt_idx;
  logic        w_sample;
  logic        w_mis;
  logic [5:0]  w_fc_nxt;
  logic        w_stop;

  // Lowest enabled sel group at or above 'from'; returns {found, sel}.
  function automatic logic [3:0] find_sel(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] res;
    res = 4'b0000;
    for (int s = 7; s >= 0; s--) begin
      if (mask[s] && (s >= int'(from))) res = {1'b1, 3'(s)};
    end
    return res;
  endfunction

  assign w_first       = find_sel(sel_mask, 4'd0);
  assign w_next        = find_sel(r_mask, {1'b0, r_idx[4:2]} + 4'd1);
  assign w_last_in_grp = &r_idx[1:0];
  assign w_nxt_vld     = !w_last_in_grp || w_next[3];
  assign w_nxt_idx     = w_last_in_grp ? {w_next[2:0], 2'b00} : (r_idx + 5'd1);
  assign w_sample      = (r_cnt == SETTLE_M1);
  assign w_mis         = (dut_out != GOLDEN[r_idx]);
  assign w_fc_nxt      = r_fc + {5'b00000, w_mis};

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_mis;
`else
  assign w_stop = 1'b0;
`endif

  // Sequencer FSM: walks enabled vectors, samples the gate unit and accumulates results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mask   <= 8'h00;
      r_idx    <= 5'd0;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_fc     <= 6'd0;
      r_ffi    <= 5'd0;
      r_result <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_mask   <= sel_mask;
            r_result <= 32'h0;
            r_fc     <= 6'd0;
            r_ffi    <= 5'd0;
            r_cnt    <= 4'd0;
            if (w_first[3]) begin
              r_idx   <= {w_first[2:0], 2'b00};
              r_busy  <= 1'b1;
              r_pass  <= 1'b0;
              r_state <= S_RUN;
            end else begin
              // Empty mask: nothing to test, report a trivially passing run.
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            // Discard any sample due on this edge; partial results stay visible.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_idx   <= 5'd0;
            r_cnt   <= 4'd0;
          end else if (w_sample) begin
            r_cnt           <= 4'd0;
            r_result[r_idx] <= dut_out;
            r_fc            <= w_fc_nxt;
            if (w_mis && (r_fc == 6'd0)) r_ffi <= r_idx;
            if (w_stop || !w_nxt_vld) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_fc_nxt == 6'd0);
              r_idx   <= 5'd0;
            end else begin
              r_idx <= w_nxt_idx;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_idx is held at 0 outside RUN, so it drives the gate unit directly.
  assign dut_sel        = r_idx[4:2];
  assign dut_a          = r_idx[1];
  assign dut_b          = r_idx[0];
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail_count     = r_fc;
  assign first_fail_idx = r_ffi;
  assign result         = r_result;

endmodule
